// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel-array datapath.
package vga_pkg;
  localparam int H_RES    = 320;
  localparam int V_RES    = 200;
  localparam int FB_WORDS = H_RES * V_RES;
  localparam int COLOR_W  = 12;
  localparam int ADDR_W   = 16;

  typedef logic [COLOR_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} fill_state_t;

  // y*320 built from two shifts so no multiplier is inferred
  function automatic fb_addr_t line_base(input logic [7:0] y);
    fb_addr_t y_ext;
    y_ext = {8'b0, y};
    return (y_ext << 8) + (y_ext << 6);
  endfunction
endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle against the frame; flags rectangles with no visible pixels.
module rect_clip
  import vga_pkg::*;
(
  input  logic [8:0] x,
  input  logic [7:0] y,
  input  logic [8:0] w,
  input  logic [7:0] h,
  output logic [9:0] x_end,
  output logic [9:0] y_end,
  output logic       empty
);
  logic [9:0] x_sum;
  logic [9:0] y_sum;

  // 10-bit sums cannot overflow: 511+511 and 255+255 both fit
  assign x_sum = {1'b0, x} + {1'b0, w};
  assign y_sum = {2'b0, y} + {2'b0, h};

  assign x_end = (x_sum > 10'(H_RES)) ? 10'(H_RES) : x_sum;
  assign y_end = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;

  assign empty = ({1'b0, x} >= 10'(H_RES)) || ({2'b0, y} >= 10'(V_RES)) ||
                 (w == 9'd0) || (h == 8'd0);
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: takes one clipped fill command and streams one pixel write per cycle.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   CLIP  | clip bounds latched, choose FILL or DONE
//   FILL  | one pixel write registered per cycle, row-major
//   DONE  | stream finished, done pulse registered for next cycle
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic               main_clk,
  input  logic               main_rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x,
  input  logic [7:0]         cmd_y,
  input  logic [8:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               done,
  output logic               do_write,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [COLOR_W-1:0] write_data
);
  fill_state_t state_q, state_d;

  logic [8:0] x_q;
  logic [7:0] y_q;
  logic [8:0] w_q;
  logic [7:0] h_q;
  pixel_t     color_q;
  logic [9:0] x_end_q, y_end_q;
  logic [9:0] cur_x, cur_y;
  fb_addr_t   row_base;

  logic [9:0] clip_x_end, clip_y_end;
  logic       clip_empty;
  logic       row_end, last_row;

  rect_clip u_clip (
    .x     (x_q),
    .y     (y_q),
    .w     (w_q),
    .h     (h_q),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  assign row_end  = (cur_x + 10'd1) == x_end_q;
  assign last_row = (cur_y + 10'd1) == y_end_q;

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = CLIP;
      end
      CLIP:    state_d = clip_empty ? DONE : FILL;
      FILL:    if (row_end && last_row) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (!main_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      row_base   <= '0;
      done       <= 1'b0;
      do_write   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      do_write <= 1'b0;
      done     <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
          end
        end
        CLIP: begin
          x_end_q  <= clip_x_end;
          y_end_q  <= clip_y_end;
          cur_x    <= {1'b0, x_q};
          cur_y    <= {2'b0, y_q};
          row_base <= line_base(y_q);
        end
        FILL: begin
          do_write   <= 1'b1;
          write_addr <= row_base + fb_addr_t'(cur_x);
          write_data <= color_q;
          if (row_end) begin
            cur_x    <= {1'b0, x_q};
            cur_y    <= cur_y + 10'd1;
            row_base <= row_base + fb_addr_t'(H_RES);
          end else begin
            cur_x <= cur_x + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
